// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - state encodings, debug codes and default timing for sequence playback
package playback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ON   = 3'd2,
    ST_OFF  = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [3:0] DB_INVALID = 4'd9;

  localparam int DEF_T_ON       = 1000;
  localparam int DEF_T_OFF      = 500;
  localparam int DEF_T_ON_FAST  = 500;
  localparam int DEF_T_OFF_FAST = 250;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Debug codes of the legal states are the state encodings widened to 4 bits.
  function automatic logic [3:0] db_code(input state_t s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/sequence_playback_ctrl_if.sv
// rtl/sequence_playback_ctrl_if.sv - control handshake and sequence memory port of the playback block
interface sequence_playback_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              start;
  logic              fast;
  logic [ADDR_W-1:0] limit;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output start, fast, limit, abort, mem_data,
    input  busy, done, mem_addr
  );

  modport slave (
    input  start, fast, limit, abort, mem_data,
    output busy, done, mem_addr
  );
endinterface

// File: rtl/playback_timer.sv
// rtl/playback_timer.sv - up-counter with clear/enable and a terminal-minus-one flag
module playback_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         fim
);
  logic [W-1:0] count;
  logic [W-1:0] last;

  // Modular subtraction lets a terminal of exactly 2^W (stored as 0) still mean 2^W-1.
  assign last = terminal - W'(1);
  assign fim  = (count == last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + W'(1);
  end
endmodule

// File: rtl/sequence_playback_ctrl.sv
// rtl/sequence_playback_ctrl.sv - walks sequence memory 0..limit, showing each entry on the LEDs
module sequence_playback_ctrl
  import playback_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int T_ON       = DEF_T_ON,
  parameter int T_OFF      = DEF_T_OFF,
  parameter int T_ON_FAST  = DEF_T_ON_FAST,
  parameter int T_OFF_FAST = DEF_T_OFF_FAST
) (
  input  logic                   clock,
  input  logic                   reset,
  sequence_playback_ctrl_if.slave bus,
  output logic [DATA_W-1:0]      leds,
  output logic [3:0]             db_estado
);
  localparam int T_MAX = max4(T_ON, T_OFF, T_ON_FAST, T_OFF_FAST);
  localparam int TW    = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

  localparam logic [TW-1:0] ON_N  = TW'(T_ON);
  localparam logic [TW-1:0] OFF_N = TW'(T_OFF);
  localparam logic [TW-1:0] ON_F  = TW'(T_ON_FAST);
  localparam logic [TW-1:0] OFF_F = TW'(T_OFF_FAST);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] limit_q;
  logic              fast_q;
  logic [DATA_W-1:0] pattern;

  logic              t_clear, t_en, t_fim;
  logic [TW-1:0]     t_term;
  logic              abort_now;

  assign abort_now = bus.abort && (state != ST_IDLE);

  playback_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (t_clear),
    .enable   (t_en),
    .terminal (t_term),
    .fim      (t_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    t_clear   = 1'b0;
    t_en      = 1'b0;
    t_term    = fast_q ? ON_F : ON_N;
    db_estado = db_code(state);
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_LOAD;
          t_clear  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nx = ST_ON;
        t_clear  = 1'b1;
      end
      ST_ON: begin
        t_en = 1'b1;
        if (t_fim) begin
          state_nx = ST_OFF;
          t_clear  = 1'b1;
        end
      end
      ST_OFF: begin
        t_term = fast_q ? OFF_F : OFF_N;
        t_en   = 1'b1;
        if (t_fim) state_nx = (addr == limit_q) ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: state_nx = ST_LOAD;
      ST_DONE: state_nx = ST_IDLE;
      default: begin
        state_nx  = ST_IDLE;
        db_estado = DB_INVALID;
      end
    endcase
    if (abort_now) begin
      state_nx = ST_IDLE;
      t_clear  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      limit_q <= '0;
      fast_q  <= 1'b0;
      pattern <= '0;
    end else if (abort_now) begin
      addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            addr    <= '0;
            limit_q <= bus.limit;
            fast_q  <= bus.fast;
          end
        end
        ST_LOAD: pattern <= bus.mem_data;
        ST_NEXT: addr    <= addr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.mem_addr = addr;
  assign bus.busy     = (state != ST_IDLE);
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign bus.done     = (state == ST_DONE) && !bus.abort;
  assign leds         = (state == ST_ON) ? pattern : '0;
endmodule
